// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared types, mode constants and one-hot helper for decoder_seq
//
// Purpose: state encoding, mode encoding and the index-to-one-hot helper used
// by the select decoder. No ports.
package decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_SCAN  = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest decoder the helper can serve (SEL_W up to 8).
  localparam int unsigned ONEHOT_MAX = 256;

  // Returns a single set bit at position idx, or zero when idx is outside the
  // out_w legal targets. Callers size-cast the result down to their OUT_W.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input int unsigned idx,
                                                   input int unsigned out_w);
    logic [ONEHOT_MAX-1:0] r;
    r = '0;
    if (idx < out_w && idx < ONEHOT_MAX) begin
      r = {{(ONEHOT_MAX-1){1'b0}}, 1'b1} << idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_dwell_timer.sv
// rtl/decoder_dwell_timer.sv - loadable dwell down-counter with step pulse
//
// Purpose: times how long each scan index stays active.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : load value into both the counter and the reload register
//   value    : dwell value (cycles-per-step minus one)
//   run      : count enable
//   step     : high in a running cycle where the counter is at zero; the
//              counter reloads on that edge, so a step occurs every value+1
//              running cycles
module decoder_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] value,
  input  logic               run,
  output logic               step
);

  logic [DWELL_W-1:0] count_q, count_d;
  logic [DWELL_W-1:0] reload_q, reload_d;

  assign step = run & (count_q == '0);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    if (load) begin
      count_d  = value;
      reload_d = value;
    end else if (run) begin
      count_d = step ? reload_q : count_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - registered binary-to-one-hot select decoder with direct and scan modes
//
// Purpose: drives one of OUT_W one-hot select lines. A valid/ready handshake
// loads a select code; DIRECT holds that line, SCAN steps the active line
// through all targets with a programmable dwell.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : global enable, low forces outputs off
//   mode      : 0 = DIRECT, 1 = SCAN, sampled every cycle
//   sel_valid : select code offered
//   sel       : select code / scan start index
//   sel_ready : combinational accept-ready
//   dwell     : cycles-per-step minus one, sampled at accept
//   op        : registered one-hot output (or zero)
//   op_idx    : registered index of the active bit (0 when op is zero)
//   busy      : registered, high while scanning
//   err       : registered one-cycle pulse on an out-of-range accept
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   op,
  output logic [SEL_W-1:0]   op_idx,
  output logic               busy,
  output logic               err
);

  // One extra bit so OUT_W == 2**SEL_W is representable for the range check.
  localparam logic [SEL_W:0]   OUT_LIM  = OUT_W[SEL_W:0];
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   op_q, op_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               accept;
  logic               in_range;
  logic               step;
  logic               tmr_load;
  logic               tmr_run;
  logic [DWELL_W-1:0] tmr_value;

  // rst term keeps ready low while reset is asserted, even if en is high.
  assign sel_ready = en & ~rst & (state_q != ST_SCAN);
  assign accept    = sel_valid & sel_ready;
  assign in_range  = {1'b0, sel} < OUT_LIM;

  // Loading zero while disabled doubles as the counter clear.
  assign tmr_load  = ~en | accept;
  assign tmr_value = accept ? dwell : '0;
  assign tmr_run   = en & (state_q == ST_SCAN) & (mode == MODE_SCAN);

  decoder_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .run   (tmr_run),
    .step  (step)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else if (accept) begin
      // An accept wins over a same-cycle mode change; mode as sampled now
      // decides whether this becomes a hold or a scan.
      if (!in_range) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        err_d   = 1'b1;
      end else begin
        idx_d   = sel;
        state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_DRIVE;
      end
    end else begin
      case (state_q)
        ST_DRIVE: begin
          if (mode != MODE_DIRECT) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
        ST_SCAN: begin
          if (mode != MODE_SCAN) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else if (step) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + SEL_W'(1);
          end
        end
        default: ;
      endcase
    end
    // Output is derived from a single index, so it can never be multi-hot.
    op_d   = (state_d == ST_IDLE) ? '0 : OUT_W'(onehot(32'(idx_d), OUT_W));
    busy_d = (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign op     = op_q;
  assign op_idx = idx_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - scoreboard testbench for decoder_seq (OUT_W=8 and OUT_W=6 instances)
module tb_decoder_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, sel_valid;
  logic [2:0] sel;
  logic [7:0] dwell;

  logic       rdy_a, busy_a, err_a;
  logic [7:0] op_a;
  logic [2:0] idx_a;

  logic       rdy_b, busy_b, err_b;
  logic [5:0] op_b;
  logic [2:0] idx_b;

  decoder_seq #(.SEL_W(3), .OUT_W(8), .DWELL_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .sel_ready(rdy_a), .dwell(dwell), .op(op_a), .op_idx(idx_a),
    .busy(busy_a), .err(err_a)
  );

  decoder_seq #(.SEL_W(3), .OUT_W(6), .DWELL_W(8)) u_dut6 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid),
    .sel(sel), .sel_ready(rdy_b), .dwell(dwell), .op(op_b), .op_idx(idx_b),
    .busy(busy_b), .err(err_b)
  );

  typedef struct {
    logic [7:0] op;
    logic [2:0] idx;
    logic       busy;
    logic       err;
    logic       rdy;
    logic       chk_b;
    logic [5:0] op_b;
    logic       err_b;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] op, input logic [2:0] idx,
                              input logic busy, input logic err, input logic rdy);
    exp_t e;
    e.op = op; e.idx = idx; e.busy = busy; e.err = err; e.rdy = rdy;
    e.chk_b = 1'b0; e.op_b = '0; e.err_b = 1'b0;
    return e;
  endfunction

  function automatic exp_t with_b(input exp_t e, input logic [5:0] ob, input logic eb);
    exp_t r;
    r = e;
    r.chk_b = 1'b1; r.op_b = ob; r.err_b = eb;
    return r;
  endfunction

  // Drive one cycle of stimulus (e.rdy is the ready expected before the edge,
  // the rest is what the registered outputs must show after the edge).
  task automatic cyc(input logic en_i, input logic mode_i, input logic valid_i,
                     input logic [2:0] sel_i, input logic [7:0] dw_i, input exp_t e);
    exp_t x;
    en = en_i; mode = mode_i; sel_valid = valid_i; sel = sel_i; dwell = dw_i;
    sb.push_back(e);
    #1;
    check("sel_ready", {31'd0, rdy_a}, {31'd0, e.rdy});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("op", {24'd0, op_a}, {24'd0, x.op});
    check("op_idx", {29'd0, idx_a}, {29'd0, x.idx});
    check("busy", {31'd0, busy_a}, {31'd0, x.busy});
    check("err", {31'd0, err_a}, {31'd0, x.err});
    if (x.chk_b) begin
      check("op_w6", {26'd0, op_b}, {26'd0, x.op_b});
      check("err_w6", {31'd0, err_b}, {31'd0, x.err_b});
    end
  endtask

  initial begin
    logic [7:0] sop;
    logic [2:0] sidx;

    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = '0;
    @(posedge clk);
    #1;
    en = 1'b1;
    #1;
    check("rst_ready", {31'd0, rdy_a}, 32'd0);
    check("rst_op", {24'd0, op_a}, 32'd0);
    check("rst_idx", {29'd0, idx_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    en = 1'b0;
    rst = 1'b0;

    // DIRECT accept of sel=5, then hold
    cyc(1, 0, 1, 3'd5, 8'd0, with_b(mk(8'h20, 3'd5, 0, 0, 1), 6'h20, 0));
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 3'd5, 8'd0, mk(8'h20, 3'd5, 0, 0, 1));

    // sel=7: legal for 8 outputs, out of range for 6 outputs
    cyc(1, 0, 1, 3'd7, 8'd0, with_b(mk(8'h80, 3'd7, 0, 0, 1), 6'h00, 1));
    cyc(1, 0, 0, 3'd7, 8'd0, with_b(mk(8'h80, 3'd7, 0, 0, 1), 6'h00, 0));

    // SCAN from 6 with dwell=2, wrapping 7 -> 0; offered codes are ignored
    cyc(1, 1, 1, 3'd6, 8'd2, with_b(mk(8'h40, 3'd6, 1, 0, 1), 6'h00, 1));
    for (int i = 0; i < 8; i++) begin
      sop  = (i < 2) ? 8'h40 : (i < 5) ? 8'h80 : 8'h01;
      sidx = (i < 2) ? 3'd6 : (i < 5) ? 3'd7 : 3'd0;
      cyc(1, 1, 1, 3'd1, 8'd5, mk(sop, sidx, 1, 0, 0));
    end

    // en drop mid-scan; err suppressed while disabled
    cyc(0, 1, 1, 3'd7, 8'd0, with_b(mk(8'h00, 3'd0, 0, 0, 0), 6'h00, 0));
    cyc(1, 1, 0, 3'd0, 8'd0, mk(8'h00, 3'd0, 0, 0, 1));
    // fresh scan with dwell=0 steps every cycle
    cyc(1, 1, 1, 3'd3, 8'd0, mk(8'h08, 3'd3, 1, 0, 1));
    cyc(1, 1, 0, 3'd0, 8'd0, mk(8'h10, 3'd4, 1, 0, 0));
    cyc(1, 1, 0, 3'd0, 8'd0, mk(8'h20, 3'd5, 1, 0, 0));
    // mode change stops the scan
    cyc(1, 0, 0, 3'd0, 8'd0, mk(8'h00, 3'd0, 0, 0, 0));

    // mode change while in DRIVE
    cyc(1, 0, 1, 3'd2, 8'd0, mk(8'h04, 3'd2, 0, 0, 1));
    cyc(1, 0, 0, 3'd2, 8'd0, mk(8'h04, 3'd2, 0, 0, 1));
    cyc(1, 1, 0, 3'd2, 8'd0, mk(8'h00, 3'd0, 0, 0, 1));
    cyc(1, 1, 0, 3'd2, 8'd0, mk(8'h00, 3'd0, 0, 0, 1));

    // async reset during SCAN while the dwell count sits at 1
    cyc(1, 1, 1, 3'd0, 8'd2, mk(8'h01, 3'd0, 1, 0, 1));
    cyc(1, 1, 0, 3'd0, 8'd0, mk(8'h01, 3'd0, 1, 0, 0));
    rst = 1'b1;
    #1;
    check("arst_op", {24'd0, op_a}, 32'd0);
    check("arst_idx", {29'd0, idx_a}, 32'd0);
    check("arst_busy", {31'd0, busy_a}, 32'd0);
    check("arst_ready", {31'd0, rdy_a}, 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 3'd0, 8'd0, mk(8'h00, 3'd0, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
# decoder_seq

Registered, parametrised binary-to-one-hot decoder with enable, a direct-select mode and a timed scan mode. It is the next-generation select decoder: it drives one-hot chip-select, row-select or mux-select lines for up to 2^SEL_W targets. A valid/ready handshake loads select codes, and an optional self-timed scan steps the active line through the targets with a programmable dwell.

## Interface
- SEL_W, 3, width of the select code.
- OUT_W, 8, number of one-hot outputs; legal range 2 to 2**SEL_W.
- DWELL_W, 8, width of the dwell-count input.

Reset: one clock; reset is asynchronous and active-high.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  global enable. Low forces outputs off.
- mode  in  1  0 = DIRECT, 1 = SCAN. Sampled every cycle.
- sel_valid  in  1  select code offered.
- sel  in  SEL_W  select code; in SCAN it is the start index.
- sel_ready  out  1  combinational: en & (state != SCAN).
- dwell  in  DWELL_W  cycles-per-step minus one in SCAN. Sampled at accept.
- op  out  OUT_W  registered one-hot output, or all-zero.
- op_idx  out  SEL_W  registered index of the active bit. 0 when op is zero.
- busy  out  1  registered; high while the state is SCAN.
- err  out  1  registered one-cycle pulse for an out-of-range select.

## Operation
- States: IDLE (op=0), DRIVE (one line held), SCAN (stepping).
- Accept occurs when sel_valid & sel_ready in a cycle.
- Range check: a select is in range when sel < OUT_W.

Accept with an out-of-range sel:
- Next cycle: op=0, op_idx=0, err=1, state=IDLE.

Accept in DIRECT mode with an in-range sel:
- Next cycle: op = 1<<sel, op_idx = sel, state = DRIVE.
- op holds until the next accept, en drops, or mode changes.

Accept in SCAN mode with an in-range sel:
- Next cycle: op = 1<<sel, state = SCAN.
- The dwell counter loads the latched dwell value.
- The counter decrements each cycle. At 0 the index advances and the counter reloads.
- Each index is therefore active for exactly dwell+1 cycles.
- Index wraps from OUT_W-1 to 0.
- With dwell=0 the index advances every cycle.

Leaving a state:
- A mode change while in DRIVE or SCAN gives op=0 and state=IDLE on the next cycle. The pending handshake is not consumed that cycle.
- sel_ready is low in SCAN, so a scan is stopped only by a mode change or by en dropping.
- en low: next cycle op=0, op_idx=0, busy=0, state=IDLE, dwell counter cleared.
- err is suppressed while en is low.

Output invariant: op is never multi-hot.

## Timing
- Reset values: op=0, op_idx=0, busy=0, err=0, state=IDLE, dwell counter=0.
- sel_ready = 0 during reset.
- Reset mid-scan clears all outputs asynchronously. No step completes.
- Latency from accept to op is 1 cycle. From en falling to op=0 is 1 cycle.
- Simultaneous accept and mode change: the accept uses mode as sampled in that same cycle.
- Simultaneous en fall and accept cannot occur, because sel_ready requires en.
- busy rises 1 cycle after a SCAN accept and falls 1 cycle after the scan stops.

## Structure
- Package decoder_pkg holds:
  - the state enum (IDLE, DRIVE, SCAN);
  - the mode constants MODE_DIRECT and MODE_SCAN;
  - the function onehot(idx, OUT_W), which returns zero when idx >= OUT_W.
- One sub-module, decoder_dwell_timer, holds the loadable down-counter. It takes inputs load, value and run, and outputs a step pulse at zero.
- Decode, index register and state machine stay in decoder_seq.

## Test plan
- Reset and DIRECT: reset, then en=1, mode=0, accept sel=5. Expect op=8'h20 and op_idx=5 one cycle later, held until the next accept.
- Out-of-range select: OUT_W=6, accept sel=7. Expect op=0 and a 1-cycle err pulse; state is IDLE.
- SCAN with wrap: mode=1, dwell=2, accept sel=6. Expect op 8'h40 ×3 cycles, then 8'h80 ×3, then 8'h01 ×3. busy=1 throughout; sel_ready=0.
- en drop mid-scan: op=0 and busy=0 the cycle after en falls. After en returns, sel_ready=1 and a fresh accept restarts cleanly.
- Mode change in DRIVE: op=8'h04, then mode switches to 1 with no accept. Expect op=0 next cycle and state IDLE.
- Async reset during SCAN at dwell count 1: all outputs are 0 immediately, with no index advance after release.
